// File: rtl/answer_check_module.sv
// answer_check_module
//   Player-input side of the note memory game. Four raw note buttons are
//   synchronised and debounced. Each accepted press is compared against a
//   fixed 8-note answer melody (1,2,3,1,4,2,3,4). The module emits a one-cycle
//   success or fail pulse for the jingle player. After every fully correct
//   round the round grows by one note. Past the 8-note round it wraps back to
//   START_LAST.
//
// Optional feature: define ANSWER_TIMEOUT_EN to abort a half-entered sequence
//   after TIMEOUT_CYCLES idle cycles in S_WAIT. This raises fail and restarts
//   the round. Without the macro, a round waits indefinitely.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-low reset
//   btn_in       in   4  raw button levels (async, high = pressed), btn_in[i] = note i+1
//   success      out  1  one-cycle pulse: whole sequence 0..last_index entered correctly
//   fail         out  1  one-cycle pulse: wrong note, multi-press or timeout
//   press_valid  out  1  one-cycle pulse per accepted press
//   press_note   out  4  note code 1..4 of the last accepted press (0 after a multi-press)
//   input_index  out  4  position of the next expected note, 0..last_index
//   last_index   out  4  final index of the current round, START_LAST..MAX_LAST

module answer_check_module #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLDOFF_CYCLES  = 60_000_000,
  parameter int START_LAST      = 2,
  parameter int MAX_LAST        = 7,
  parameter int TIMEOUT_CYCLES  = 250_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_in,
  output logic       success,
  output logic       fail,
  output logic       press_valid,
  output logic [3:0] press_note,
  output logic [3:0] input_index,
  output logic [3:0] last_index
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT,  // accepting presses
    S_REL,   // waiting for every button to be released
    S_HOLD   // lockout while the jingle plays
  } state_t;

  // Answer melody. The code is the note number 1..4.
  function automatic logic [2:0] answer_note(input logic [2:0] idx);
    case (idx)
      3'd0:    answer_note = 3'd1;
      3'd1:    answer_note = 3'd2;
      3'd2:    answer_note = 3'd3;
      3'd3:    answer_note = 3'd1;
      3'd4:    answer_note = 3'd4;
      3'd5:    answer_note = 3'd2;
      3'd6:    answer_note = 3'd3;
      default: answer_note = 3'd4;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------
  logic [3:0] sync1, sync2;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: each counter saturates at DEBOUNCE_CYCLES while its input is
  // high. A single low sample drops it straight back to zero.
  // ---------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      deb, deb_q, rise;

  // NOTE: this counter array is a handful of flops rather than a RAM, so it is
  // reset like any other register. This makes a mid-press reset take effect at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      deb_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!sync2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
      deb_q <= deb;
    end
  end

  logic [2:0] rise_note;
  logic       press_evt, multi_press;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    deb       = '0;
    rise_note = 3'd0;
    for (int i = 0; i < 4; i++) deb[i] = (db_cnt[i] == DB_MAX);
    rise = deb & ~deb_q;
    // Only meaningful when exactly one button is down; the lowest bit wins.
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) rise_note = 3'(i + 1);
    end
  end

  assign press_evt   = |rise;
  assign multi_press = ($countones(deb) > 1);

  // ---------------------------------------------------------------------
  // Game state machine, all outputs registered
  // ---------------------------------------------------------------------
  state_t          state;
  logic [HO_W-1:0] ho_cnt;
  logic [2:0]      expected_note;

  assign expected_note = answer_note(input_index[2:0]);

`ifdef ANSWER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_WAIT;
      ho_cnt      <= '0;
      success     <= 1'b0;
      fail        <= 1'b0;
      press_valid <= 1'b0;
      press_note  <= '0;
      input_index <= '0;
      last_index  <= 4'(START_LAST);
`ifdef ANSWER_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      success     <= 1'b0;
      fail        <= 1'b0;
      press_valid <= 1'b0;

      case (state)
        S_WAIT: begin
          if (press_evt) begin
            press_valid <= 1'b1;
`ifdef ANSWER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
            if (multi_press) begin
              // Any fail restarts the same round from its first note.
              fail        <= 1'b1;
              press_note  <= '0;
              input_index <= '0;
              state       <= S_HOLD;
            end else begin
              press_note <= {1'b0, rise_note};
              if (rise_note != expected_note) begin
                fail        <= 1'b1;
                input_index <= '0;
                state       <= S_HOLD;
              end else if (input_index == last_index) begin
                success     <= 1'b1;
                input_index <= '0;
                last_index  <= (last_index == 4'(MAX_LAST)) ? 4'(START_LAST)
                                                            : last_index + 4'd1;
                state       <= S_HOLD;
              end else begin
                input_index <= input_index + 4'd1;
                state       <= S_REL;
              end
            end
          end
`ifdef ANSWER_TIMEOUT_EN
          // The idle timer only runs once the player has started a sequence.
          // Firing at TO_LAST means the fail pulse lands on the edge where the
          // count would reach TIMEOUT_CYCLES.
          else if (input_index != 4'd0) begin
            if (to_cnt == TO_LAST) begin
              fail        <= 1'b1;
              input_index <= '0;
              to_cnt      <= '0;
              state       <= S_HOLD;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
`endif
        end

        S_HOLD: begin
          if (ho_cnt == HO_LAST) begin
            ho_cnt <= '0;
            state  <= S_REL;
          end else begin
            ho_cnt <= ho_cnt + HO_W'(1);
          end
        end

        S_REL: begin
          if (deb == 4'b0000) state <= S_WAIT;
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
